// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
// Module  : mem_access_unit_pkg
// Brief   : State encodings and access-kind codes for mem_access_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

  typedef logic [1:0] mem_state_t;
  typedef logic [1:0] mem_kind_t;

  localparam mem_state_t MEM_IDLE = 2'd0;
  localparam mem_state_t MEM_REQ  = 2'd1;
  localparam mem_state_t MEM_DONE = 2'd2;

  localparam mem_kind_t MEM_KIND_FETCH = 2'd0;
  localparam mem_kind_t MEM_KIND_LOAD  = 2'd1;
  localparam mem_kind_t MEM_KIND_STORE = 2'd2;

  // Fetch beats load beats store when strobes coincide.
  function automatic mem_kind_t mem_kind_sel(input logic fetch, input logic load);
    if (fetch)
      return MEM_KIND_FETCH;
    else if (load)
      return MEM_KIND_LOAD;
    else
      return MEM_KIND_STORE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module  : mem_access_unit_if
// Brief   : Simple req/ack memory bus between mem_access_unit and the fabric.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              busReq;
  logic              busWe;
  logic [ADDR_W-1:0] busAddr;
  logic [DATA_W-1:0] busWData;
  logic              busAck;
  logic [DATA_W-1:0] busRData;

  modport master (
    output busReq, busWe, busAddr, busWData,
    input  busAck, busRData
  );

  modport slave (
    input  busReq, busWe, busAddr, busWData,
    output busAck, busRData
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit_bus_watchdog.sv
// ============================================================================
// Module  : bus_watchdog
// Brief   : Wait-cycle counter that flags a stalled bus request.
//           Built only when MEM_TIMEOUT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef MEM_TIMEOUT_EN
module bus_watchdog #(
  parameter int LIMIT = 255
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_count <= '0;
    else if (clear)
      r_count <= '0;
    else if (enable)
      r_count <= r_count + 1'b1;
  end

  // Fires during the LIMIT-th unacknowledged wait cycle.
  assign expired = enable && (r_count == CNT_W'(LIMIT - 1));
endmodule
`endif

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module  : mem_access_unit
// Brief   : Runs one req/ack bus transaction per fetch/load/store strobe.
//           Optional request timeout enabled by defining MEM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              doFetch,
  input  wire logic              doMemoryLoad,
  input  wire logic              doMemoryStore,
  input  wire logic [ADDR_W-1:0] addr,
  input  wire logic [DATA_W-1:0] storeData,
  output logic      [DATA_W-1:0] instrOut,
  output logic      [DATA_W-1:0] loadData,
  output logic                   accessDone,
  output logic                   busy,
  output logic                   overrun,
  output logic                   busError,
  mem_access_unit_if.master      bus
);

  mem_state_t        r_state;
  mem_kind_t         r_kind;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] r_load;
  logic              r_overrun;
  logic              w_strobe;
  logic              w_expired;

  assign w_strobe = doFetch || doMemoryLoad || doMemoryStore;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MEM_IDLE;
      r_kind    <= MEM_KIND_FETCH;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_instr   <= '0;
      r_load    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_strobe && (r_state != MEM_IDLE);
      case (r_state)
        MEM_IDLE: begin
          if (w_strobe) begin
            r_kind  <= mem_kind_sel(doFetch, doMemoryLoad);
            r_addr  <= addr;
            r_wdata <= storeData;
            r_state <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          // An ack in the timeout cycle still completes normally.
          if (bus.busAck) begin
            if (r_kind == MEM_KIND_FETCH)
              r_instr <= bus.busRData;
            else if (r_kind == MEM_KIND_LOAD)
              r_load <= bus.busRData;
            r_state <= MEM_DONE;
          end else if (w_expired) begin
            r_state <= MEM_DONE;
          end
        end
        MEM_DONE: r_state <= MEM_IDLE;
        default:  r_state <= MEM_IDLE;
      endcase
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_error;

  bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (r_state != MEM_REQ),
    .enable  ((r_state == MEM_REQ) && !bus.busAck),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_error <= 1'b0;
    else if (w_expired)
      r_error <= 1'b1;
  end

  assign busError = r_error;
`else
  logic w_unused_timeout;

  assign w_expired        = 1'b0;
  assign busError         = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign bus.busReq   = (r_state == MEM_REQ);
  assign bus.busWe    = (r_state == MEM_REQ) && (r_kind == MEM_KIND_STORE);
  assign bus.busAddr  = r_addr;
  assign bus.busWData = r_wdata;
  assign accessDone   = (r_state == MEM_DONE);
  assign busy         = (r_state != MEM_IDLE);
  assign overrun      = r_overrun;
  assign instrOut     = r_instr;
  assign loadData     = r_load;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Self-checking bench for mem_access_unit (vector table, corner
//           sequences, random transactions against a transaction-level model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        doFetch = 1'b0;
  logic        doMemoryLoad = 1'b0;
  logic        doMemoryStore = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] storeData = '0;
  logic [31:0] instrOut;
  logic [31:0] loadData;
  logic        accessDone;
  logic        busy;
  logic        overrun;
  logic        busError;

  mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  mem_access_unit #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .doFetch       (doFetch),
    .doMemoryLoad  (doMemoryLoad),
    .doMemoryStore (doMemoryStore),
    .addr          (addr),
    .storeData     (storeData),
    .instrOut      (instrOut),
    .loadData      (loadData),
    .accessDone    (accessDone),
    .busy          (busy),
    .overrun       (overrun),
    .busError      (busError),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level reference state
  logic [31:0] m_instr = '0;
  logic [31:0] m_load  = '0;
  logic        m_err   = 1'b0;

  typedef struct {
    logic [2:0]  strb;      // {fetch, load, store}
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    int          dly;
    int          ovr_at;    // wait-cycle index of a stray strobe, dly+1 = DONE, -1 none
    logic        exp_we;
    logic [31:0] exp_instr;
    logic [31:0] exp_load;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [2:0] strb, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly, input int ovr_at);
    logic is_f, is_l, is_s, ovr_exp;
    is_f = strb[2];
    is_l = !strb[2] && strb[1];
    is_s = !strb[2] && !strb[1];
    doFetch = strb[2]; doMemoryLoad = strb[1]; doMemoryStore = strb[0];
    addr = a; storeData = wd;
    step();
    doFetch = 0; doMemoryLoad = 0; doMemoryStore = 0;
    addr = $urandom; storeData = $urandom;
    ovr_exp = 1'b0;
    for (int i = 0; i <= dly; i++) begin
      chk("busReq_wait", 32'(bus_if.busReq), 32'd1);
      chk("busy_wait", 32'(busy), 32'd1);
      chk("busWe_wait", 32'(bus_if.busWe), 32'(is_s));
      chk("busAddr_wait", bus_if.busAddr, a);
      if (is_s) chk("busWData_wait", bus_if.busWData, wd);
      chk("accessDone_wait", 32'(accessDone), 32'd0);
      chk("overrun_wait", 32'(overrun), 32'(ovr_exp));
      bus_if.busAck   = (i == dly);
      bus_if.busRData = (i == dly) ? rd : 32'($urandom);
      ovr_exp = (i == ovr_at);
      if (ovr_exp) doFetch = 1;
      step();
      bus_if.busAck = 0; doFetch = 0;
    end
    if (is_f) m_instr = rd;
    else if (is_l) m_load = rd;
    chk("accessDone_done", 32'(accessDone), 32'd1);
    chk("busReq_done", 32'(bus_if.busReq), 32'd0);
    chk("busy_done", 32'(busy), 32'd1);
    chk("overrun_done", 32'(overrun), 32'(ovr_exp));
    chk("instrOut", instrOut, m_instr);
    chk("loadData", loadData, m_load);
    chk("busError", 32'(busError), 32'(m_err));
    ovr_exp = (ovr_at == dly + 1);
    if (ovr_exp) doFetch = 1;
    step();
    doFetch = 0;
    chk("accessDone_after", 32'(accessDone), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("busReq_after", 32'(bus_if.busReq), 32'd0);
    chk("overrun_after", 32'(overrun), 32'(ovr_exp));
    if (ovr_exp) begin
      step();
      chk("busReq_dropped", 32'(bus_if.busReq), 32'd0);
      chk("busy_dropped", 32'(busy), 32'd0);
      chk("overrun_single", 32'(overrun), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busReq"}, 32'(bus_if.busReq), 32'd0);
    chk({tag, "_busWe"}, 32'(bus_if.busWe), 32'd0);
    chk({tag, "_busAddr"}, bus_if.busAddr, 32'd0);
    chk({tag, "_busWData"}, bus_if.busWData, 32'd0);
    chk({tag, "_instrOut"}, instrOut, 32'd0);
    chk({tag, "_loadData"}, loadData, 32'd0);
    chk({tag, "_accessDone"}, 32'(accessDone), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_busError"}, 32'(busError), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    vecs[0] = '{3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, -1, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{3'b001, 32'h20,  32'h12345678, 32'hAAAA5555, 3, -1, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{3'b101, 32'h40,  32'h0BAD0BAD, 32'hE3A00001, 1, -1, 1'b0, 32'hE3A00001, 32'hDEADBEEF};
    vecs[3] = '{3'b110, 32'h44,  32'h0,        32'h11112222, 0, -1, 1'b0, 32'h11112222, 32'hDEADBEEF};
    vecs[4] = '{3'b011, 32'h48,  32'h77777777, 32'hCAFEF00D, 2, -1, 1'b0, 32'h11112222, 32'hCAFEF00D};
    vecs[5] = '{3'b100, 32'h4C,  32'h0,        32'h55667788, 2,  0, 1'b0, 32'h55667788, 32'hCAFEF00D};
    vecs[6] = '{3'b010, 32'h50,  32'h0,        32'h0F0F0F0F, 0,  1, 1'b0, 32'h55667788, 32'h0F0F0F0F};

    bus_if.busAck = 0;
    bus_if.busRData = '0;

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    rst_n = 1;
    step();
    chk_all_zero("after_reset");

    // Vector table
    for (int v = 0; v < 7; v++) begin
      run_txn(vecs[v].strb, vecs[v].a, vecs[v].wd, vecs[v].rd, vecs[v].dly, vecs[v].ovr_at);
      chk($sformatf("vec%0d_instr", v), instrOut, vecs[v].exp_instr);
      chk($sformatf("vec%0d_load", v), loadData, vecs[v].exp_load);
    end

    // Ack while idle must be ignored
    bus_if.busAck = 1; bus_if.busRData = 32'h99999999;
    step();
    step();
    bus_if.busAck = 0;
    chk("idle_ack_done", 32'(accessDone), 32'd0);
    chk("idle_ack_busy", 32'(busy), 32'd0);
    chk("idle_ack_instr", instrOut, m_instr);
    chk("idle_ack_load", loadData, m_load);

`ifdef MEM_TIMEOUT_EN
    // Unanswered load: abort after TO wait cycles, sticky error
    doMemoryLoad = 1; addr = 32'h300;
    step();
    doMemoryLoad = 0;
    for (int i = 0; i < TO; i++) begin
      chk("to_busReq", 32'(bus_if.busReq), 32'd1);
      chk("to_accessDone", 32'(accessDone), 32'd0);
      step();
    end
    m_err = 1'b1;
    chk("to_done", 32'(accessDone), 32'd1);
    chk("to_busReq_drop", 32'(bus_if.busReq), 32'd0);
    chk("to_error", 32'(busError), 32'd1);
    chk("to_load_kept", loadData, m_load);
    step();
    chk("to_done_once", 32'(accessDone), 32'd0);
    chk("to_error_sticky", 32'(busError), 32'd1);
    // Ack landing in the timeout cycle completes normally
    run_txn(3'b100, 32'h304, 32'h0, 32'h13579BDF, TO - 1, -1);
`endif

    // Random transactions against the model
    for (int n = 0; n < 40; n++) begin
      int d, o;
      d = int'($urandom_range(0, 3));
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d + 1)) : -1;
      run_txn(3'($urandom_range(1, 7)), $urandom, $urandom, $urandom, d, o);
      if ($urandom_range(0, 1) == 1) step();
    end

    // Reset in the middle of a request, then a late ack
    doMemoryLoad = 1; addr = 32'h600;
    step();
    doMemoryLoad = 0;
    chk("rst_pre_busReq", 32'(bus_if.busReq), 32'd1);
    #2 rst_n = 0;
    #1;
    chk_all_zero("mid_reset");
    step();
    rst_n = 1;
    m_instr = '0; m_load = '0; m_err = 1'b0;
    bus_if.busAck = 1; bus_if.busRData = 32'hFFFF0000;
    step();
    bus_if.busAck = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_done", 32'(accessDone), 32'd0);
      chk("late_ack_busReq", 32'(bus_if.busReq), 32'd0);
      chk("late_ack_load", loadData, 32'd0);
      step();
    end
    run_txn(3'b010, 32'h604, 32'h0, 32'h24681357, 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Responder side of the control-unit strobe interface. Services doFetch, doMemoryLoad and doMemoryStore by running one transaction on a simple req/ack memory bus. Returns the fetched instruction or the loaded word, plus a one-cycle accessDone pulse the control FSM waits on before advancing controlState. Sits between the control unit and the memory/bus fabric.

Parameters:
ADDR_W, 32, width of the access address and busAddr
DATA_W, 32, width of the data path
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before abort (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
doFetch  in  1  one-cycle strobe: read instruction at addr
doMemoryLoad  in  1  one-cycle strobe: read data at addr
doMemoryStore  in  1  one-cycle strobe: write storeData to addr
addr  in  ADDR_W  access address, sampled with the strobe
storeData  in  DATA_W  write data, sampled with the strobe
instrOut  out  DATA_W  last fetched instruction, held
loadData  out  DATA_W  last loaded word, held
accessDone  out  1  one-cycle pulse when the transaction completes
busy  out  1  high from the cycle after an accepted strobe through the DONE cycle
overrun  out  1  one-cycle pulse: strobe arrived while busy, dropped
busReq  out  1  bus request, held until ack
busWe  out  1  write enable, valid with busReq
busAddr  out  ADDR_W  bus address, valid with busReq
busWData  out  DATA_W  bus write data, valid with busReq
busAck  in  1  bus acknowledge, one cycle; read data valid with it
busRData  in  DATA_W  bus read data
busError  out  1  sticky timeout flag (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including instrOut, loadData and busError. Asserting reset mid-transaction drops busReq immediately. Any bus ack that arrives after reset is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE: on any strobe, latch addr, storeData and access kind, then go to REQ. busy=1 next cycle.
- Strobe priority if several are high together: fetch > load > store. Lower-priority strobes are dropped with no overrun pulse.
- REQ: busReq=1, busWe=(kind==store), busAddr and busWData driven from the latches and stable until ack.
  - On busAck=1: capture busRData into instrOut (fetch) or loadData (load); a store leaves both unchanged. Drop busReq on the next edge and go to DONE.
  - busAck seen while busReq=0 is ignored.
- DONE: accessDone=1 for exactly one cycle, then IDLE. busy falls in the cycle after DONE.
- Latency: strobe at edge N, busReq high in cycle N+1. Ack in cycle N+1 gives accessDone in cycle N+2, so the minimum is 2 cycles from strobe to done. Each added ack wait adds one cycle.
- A strobe in REQ or DONE: overrun pulses 1 cycle and the strobe is dropped. A strobe arriving in the same cycle accessDone is asserted is also dropped; the control unit must issue its next strobe only after accessDone.
- instrOut and loadData hold their values until overwritten by a later access of the same kind.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: a counter clears on entry to REQ and increments each REQ cycle without ack. If it reaches TIMEOUT_CYCLES: busReq drops, busError is set sticky (cleared only by reset), accessDone pulses, read targets are left unchanged, state returns to IDLE. An ack in the same cycle as the timeout wins (normal completion, no error).
- Undefined: no counter; REQ waits indefinitely; busError tied 0.

Decomposition:
- Defines.v: state encodings MEM_IDLE, MEM_REQ, MEM_DONE, and access-kind codes MEM_KIND_FETCH, MEM_KIND_LOAD, MEM_KIND_STORE.
- One sub-module, bus_watchdog: counter, clear and enable inputs, expired output. Instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- doMemoryLoad, addr=0x100; bus acks next cycle with 0xDEADBEEF -> busReq high 1 cycle, busWe=0, loadData=0xDEADBEEF, accessDone in cycle N+2, instrOut unchanged.
- doMemoryStore, addr=0x20, storeData=0x12345678; ack delayed 3 cycles -> busWe=1, busAddr and busWData stable 4 cycles, accessDone in cycle N+5, loadData unchanged.
- doFetch and doMemoryStore in the same cycle -> only a fetch runs (busWe=0), no overrun pulse.
- doFetch while in REQ -> overrun pulses 1 cycle; exactly one accessDone.
- Reset asserted in REQ, then ack arrives -> busReq 0 immediately, all outputs 0, no accessDone, ack ignored.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> busReq drops after 4 REQ cycles, busError=1 sticky, one accessDone pulse.
